l1_lsu_requester: RTL
=====================

# l1_lsu_requester

Load/store requester that drives the L1 data memory port from the core's execute stage. Accepts one RV32I load or store per transaction and aligns store data into byte lanes with a write mask. Holds the request stable while the memory asserts stall, then extracts and sign- or zero-extends the load result. Sits between the pipeline's memory stage and the L1 data memory bank array.

## Interface
- None: address and data widths are fixed at 32 bits.

- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  pipeline presents a request
- req_ready  out  1  requester can accept; transfer when req_valid && req_ready
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle pulse; result/status valid
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  illegal funct3, or misaligned with trap enabled
- mem_read_en  out  1  read strobe to memory
- mem_read_addr  out  32  word-aligned read address (low two bits 0)
- mem_write_en  out  1  write strobe to memory
- mem_write_addr  out  32  word-aligned write address
- mem_write_mask  out  4  byte-lane enables, bit 0 = bits [7:0]
- mem_write_data  out  32  lane-replicated store data
- mem_read_data  in  32  combinational read data from memory
- mem_stall  in  1  memory not ready; hold access

## Operation
- States: IDLE, ACCESS, RESP. req_ready = (state == IDLE) || (state == RESP).
- Accept: the request is registered (addr, funct3, is_store, wdata). A legal access goes to ACCESS. An error goes directly to RESP with resp_err=1.
- ACCESS: memory outputs are driven from the registered request only in this state.
  - Load: mem_read_en=1.
  - Store: mem_write_en=1.
  - mem_stall=1: stay in ACCESS.
  - mem_stall=0: capture the formatted load data, then go to RESP.
- RESP: resp_valid=1 for one cycle. If a new request is accepted in this cycle, go to ACCESS (or to RESP for an error). Otherwise go to IDLE.
- Store lane formatting:
  - SB: data = {4{wdata[7:0]}}, mask = 4'b0001 << addr[1:0].
  - SH: data = {2{wdata[15:0]}}, mask = 4'b0011 << {addr[1],1'b0}.
  - SW: data = wdata, mask = 4'b1111.
- Load extraction: select the byte or halfword by addr[1:0] or addr[1]. LB/LH sign-extend; LBU/LHU/LW zero-extend or pass through.
- Illegal funct3 for loads: 011, 110, 111. Illegal funct3 for stores: anything except 000/001/010. Illegal requests never touch memory.
- The memory commits a write at every edge where mem_write_en=1. Repeated writes during a stall are identical and therefore harmless.
- Memory address outputs hold their last value outside ACCESS. Enables are 0 outside ACCESS.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, all mem_* outputs 0.
- Latency with no stall: accept at edge N, memory access in cycle N..N+1, resp_valid high in the cycle after edge N+1.
- Each stall cycle adds one cycle of latency. Memory outputs stay bit-stable throughout the stall.
- Error response: resp_valid in the cycle after the accept edge.
- Throughput: one transaction every 2 cycles, back-to-back via RESP.
- Reset asserted during ACCESS:
  - The state returns to IDLE at that edge.
  - A store whose mem_write_en is high at that same edge may still commit.
  - No resp_valid is issued for the aborted request.

## Configuration
- MISALIGN_TRAP_EN defined: misaligned requests are accepted, never reach memory, and respond with resp_err=1 and resp_rdata=0. A request is misaligned when:
  - H/HU with addr[0]=1, or
  - W with addr[1:0]!=0.
- MISALIGN_TRAP_EN undefined: misalignment is not checked.
  - Halfword accesses use addr[1] only.
  - Word accesses ignore addr[1:0].
  - resp_err is raised only for illegal funct3.

## Test plan
- LB, then LBU at 0x13 with memory word 0x80FF7F01 at 0x10 -> mem_read_addr=0x10; resp_rdata=0xFFFFFF80, then 0x00000080.
- SB addr 0x12, wdata 0x000000AB -> mem_write_mask=4'b0100, mem_write_data=0xABABABAB; a readback LW at 0x10 shows byte 2 = 0xAB.
- LW at 0x20 with mem_stall high for 3 cycles -> memory outputs stable throughout; resp_valid arrives 3 cycles later than the no-stall case; req_ready stays 0 during the stall.
- LW at 0x06:
  - With MISALIGN_TRAP_EN: resp_err=1, no enable ever asserted.
  - Without it: mem_read_addr=0x04, data returned, resp_err=0.
- Load with funct3=011 -> no memory access; resp_valid with resp_err=1 one cycle after accept.
- Reset asserted during ACCESS of an LH -> the next cycle is IDLE with req_ready=1; no resp_valid; a new SW afterwards completes normally.

Source files
------------

// File: rtl/l1_lsu_requester_if.sv
// Bundle of the pipeline request/response handshake and the L1 data memory port.
// slave = the requester, master = whoever drives requests and models memory.
interface l1_lsu_requester_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read_en;
  logic [31:0] mem_read_addr;
  logic        mem_write_en;
  logic [31:0] mem_write_addr;
  logic [3:0]  mem_write_mask;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_stall;

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    input  mem_read_data, mem_stall,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_read_en, mem_read_addr, mem_write_en, mem_write_addr,
    output mem_write_mask, mem_write_data
  );

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    output mem_read_data, mem_stall,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_read_en, mem_read_addr, mem_write_en, mem_write_addr,
    input  mem_write_mask, mem_write_data
  );
endinterface

// File: rtl/l1_lsu_requester.sv
// RV32I load/store requester driving the L1 data memory port (IDLE/ACCESS/RESP FSM).
// Optional macro MISALIGN_TRAP_EN: misaligned H/W accesses respond with resp_err and skip memory.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; resp_valid is a
// one-cycle pulse with no backpressure; the memory holds an access while mem_stall is high.
module l1_lsu_requester (
  input  logic                      clk,
  input  logic                      reset,
  l1_lsu_requester_if.slave         bus,
  output logic [1:0]                o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_is_store;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [31:0] r_rd_addr;
  logic [31:0] r_wr_addr;
  logic [3:0]  r_wr_mask;
  logic [31:0] r_wr_data;

  logic        w_accept;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_req_err;
  logic [3:0]  w_st_mask;
  logic [31:0] w_st_data;
  logic [31:0] w_ld_shift;
  logic [31:0] w_ld_data;

  assign w_accept = bus.req_valid && bus.req_ready;

  // Request legality, evaluated on the live request so errors never reach ACCESS
  always_comb begin
    w_illegal = 1'b0;
    if (bus.req_is_store)
      w_illegal = bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11);
    else
      w_illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                  (bus.req_funct3 == 3'b111);
  end

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                      ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_req_err = w_illegal || w_misalign;

  always_comb begin
    w_st_mask = 4'b1111;
    w_st_data = bus.req_wdata;
    case (bus.req_funct3[1:0])
      2'b00: begin
        w_st_mask = 4'b0001 << bus.req_addr[1:0];
        w_st_data = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        w_st_mask = 4'b0011 << {bus.req_addr[1], 1'b0};
        w_st_data = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        w_st_mask = 4'b1111;
        w_st_data = bus.req_wdata;
      end
    endcase
  end

  // Byte loads select by the full lane; halfword loads only by lane[1]
  assign w_ld_shift = bus.mem_read_data >> {r_lane, 3'b000};

  always_comb begin
    w_ld_data = bus.mem_read_data;
    case (r_funct3)
      3'b000:  w_ld_data = {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
      3'b100:  w_ld_data = {24'd0, w_ld_shift[7:0]};
      3'b001:  w_ld_data = r_lane[1] ? {{16{bus.mem_read_data[31]}}, bus.mem_read_data[31:16]}
                                     : {{16{bus.mem_read_data[15]}}, bus.mem_read_data[15:0]};
      3'b101:  w_ld_data = r_lane[1] ? {16'd0, bus.mem_read_data[31:16]}
                                     : {16'd0, bus.mem_read_data[15:0]};
      default: w_ld_data = bus.mem_read_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next_state = w_req_err ? S_RESP : S_ACCESS;
      S_ACCESS: if (!bus.mem_stall) w_next_state = S_RESP;
      S_RESP: begin
        if (w_accept) w_next_state = w_req_err ? S_RESP : S_ACCESS;
        else          w_next_state = S_IDLE;
      end
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready    = (r_state == S_IDLE) || (r_state == S_RESP);
    bus.resp_valid   = (r_state == S_RESP);
    bus.resp_rdata   = (r_state == S_RESP) ? r_rdata : 32'd0;
    bus.resp_err     = (r_state == S_RESP) ? r_err : 1'b0;
    bus.mem_read_en  = (r_state == S_ACCESS) && !r_is_store;
    bus.mem_write_en = (r_state == S_ACCESS) && r_is_store;
  end

  assign bus.mem_read_addr  = r_rd_addr;
  assign bus.mem_write_addr = r_wr_addr;
  assign bus.mem_write_mask = r_wr_mask;
  assign bus.mem_write_data = r_wr_data;
  assign o_dbg_state        = r_state;

  // Memory-side registers load only for a legal access, so they hold outside ACCESS
  always_ff @(posedge clk) begin
    if (reset) begin
      r_is_store <= 1'b0;
      r_funct3   <= 3'd0;
      r_lane     <= 2'd0;
      r_err      <= 1'b0;
      r_rdata    <= 32'd0;
      r_rd_addr  <= 32'd0;
      r_wr_addr  <= 32'd0;
      r_wr_mask  <= 4'd0;
      r_wr_data  <= 32'd0;
    end else begin
      if (w_accept) begin
        r_is_store <= bus.req_is_store;
        r_funct3   <= bus.req_funct3;
        r_lane     <= bus.req_addr[1:0];
        r_err      <= w_req_err;
        r_rdata    <= 32'd0;
        if (!w_req_err) begin
          if (bus.req_is_store) begin
            r_wr_addr <= {bus.req_addr[31:2], 2'b00};
            r_wr_mask <= w_st_mask;
            r_wr_data <= w_st_data;
          end else begin
            r_rd_addr <= {bus.req_addr[31:2], 2'b00};
          end
        end
      end
      if ((r_state == S_ACCESS) && !bus.mem_stall && !r_is_store)
        r_rdata <= w_ld_data;
    end
  end

endmodule
